// File: rtl/isa_mem_pkg.sv
// isa_mem_pkg: definitions shared by the instruction-memory loader and the
// imem bench.
//   loader_state_t : loader FSM states (IDLE, LOAD, DONE)
//   IMEM_WIDTH     : default imem word width in bits
//   IMEM_SIZE      : default imem depth in words (need not be a power of two)
package isa_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } loader_state_t;

  localparam int unsigned IMEM_WIDTH = 32;
  localparam int unsigned IMEM_SIZE  = 23;

endpackage : isa_mem_pkg

// File: rtl/imem_loader_ptr.sv
// imem_loader_ptr: word address pointer and word counter for imem_loader.
// The pointer stops at SIZE-1 and never wraps. The counter saturates at SIZE.
//   clk     : clock, rising edge
//   reset   : synchronous active-high reset
//   clear   : return pointer and count to zero (start of a new load)
//   advance : one word accepted this cycle
//   ptr     : address of the next word to be written
//   count   : words written so far in this load (0..SIZE)
//   last    : pointer sits at SIZE-1
module imem_loader_ptr #(
  parameter  int SIZE = 23,
  localparam int AW   = $clog2(SIZE)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          advance,
  output logic [AW-1:0] ptr,
  output logic [AW:0]   count,
  output logic          last
);

  localparam logic [AW-1:0] LAST_PTR = AW'(SIZE - 1);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(SIZE);

  assign last = (ptr == LAST_PTR);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      ptr   <= '0;
      count <= '0;
    end else if (advance) begin
      if (!last) begin
        ptr <= ptr + AW'(1);
      end
      if (count != FULL_CNT) begin
        count <= count + (AW + 1)'(1);
      end
    end
  end

endmodule : imem_loader_ptr

// File: rtl/imem_loader.sv
// imem_loader: accepts a valid/ready word stream and writes it into the imem
// write port at consecutive word addresses starting from 0.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN adds a 'checksum' output,
// the modulo-2^WIDTH sum of all words accepted since the last start.
//   clk      : clock, rising edge
//   reset    : synchronous active-high reset
//   start    : one-cycle pulse, begin a load at address 0 (ignored in LOAD)
//   s_valid  : stream word valid
//   s_data   : stream word
//   s_last   : final word of the program, qualified by s_valid
//   s_ready  : loader accepts a word this cycle (high only in LOAD)
//   mem_we   : imem write enable, one cycle after each accept
//   mem_addr : imem word address
//   mem_wd   : imem write data
//   busy     : load in progress
//   done     : load finished
//   overflow : sticky, stream ran past SIZE words
//   count    : words written in the current or last load
//   checksum : (IMEM_LOADER_CHECKSUM_EN only) sum of accepted words
module imem_loader
  import isa_mem_pkg::*;
#(
  parameter  int WIDTH = IMEM_WIDTH,
  parameter  int SIZE  = IMEM_SIZE,
  localparam int AW    = $clog2(SIZE)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             s_valid,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_last,
  output logic             s_ready,
  output logic             mem_we,
  output logic [AW-1:0]    mem_addr,
  output logic [WIDTH-1:0] mem_wd,
  output logic             busy,
  output logic             done,
  output logic             overflow,
`ifdef IMEM_LOADER_CHECKSUM_EN
  output logic [WIDTH-1:0] checksum,
`endif
  output logic [AW:0]      count
);

  loader_state_t state;
  logic          accept;
  logic          launch;
  logic [AW-1:0] ptr;
  logic          ptr_last;

  // Handshake flags decode only the state register, so s_ready never
  // depends on s_valid.
  assign s_ready = (state == LOAD);
  assign busy    = (state == LOAD);
  assign done    = (state == DONE);
  assign accept  = s_valid && s_ready;
  assign launch  = start && (state != LOAD);

  imem_loader_ptr #(
    .SIZE(SIZE)
  ) u_ptr (
    .clk    (clk),
    .reset  (reset),
    .clear  (launch),
    .advance(accept),
    .ptr    (ptr),
    .count  (count),
    .last   (ptr_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_wd   <= '0;
      overflow <= 1'b0;
    end else begin
      mem_we <= accept;
      if (accept) begin
        mem_addr <= ptr;
        mem_wd   <= s_data;
      end
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= LOAD;
            overflow <= 1'b0;
          end
        end
        LOAD: begin
          if (accept) begin
            if (s_last) begin
              state <= DONE;
            end else if (ptr_last) begin
              // Memory is full and the program has not ended.
              state    <= DONE;
              overflow <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (reset || launch) begin
      checksum <= '0;
    end else if (accept) begin
      checksum <= checksum + s_data;
    end
  end
`endif

endmodule : imem_loader

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed self-checking bench for imem_loader with the
// default WIDTH = 32, SIZE = 23 configuration.
module tb_imem_loader;

  localparam int WIDTH = 32;
  localparam int SIZE  = 23;
  localparam int AW    = 5;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             s_valid;
  logic [WIDTH-1:0] s_data;
  logic             s_last;
  logic             s_ready;
  logic             mem_we;
  logic [AW-1:0]    mem_addr;
  logic [WIDTH-1:0] mem_wd;
  logic             busy;
  logic             done;
  logic             overflow;
  logic [AW:0]      count;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [WIDTH-1:0] checksum;
`endif

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  imem_loader #(
    .WIDTH(WIDTH),
    .SIZE (SIZE)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .s_valid (s_valid),
    .s_data  (s_data),
    .s_last  (s_last),
    .s_ready (s_ready),
    .mem_we  (mem_we),
    .mem_addr(mem_addr),
    .mem_wd  (mem_wd),
    .busy    (busy),
    .done    (done),
    .overflow(overflow),
`ifdef IMEM_LOADER_CHECKSUM_EN
    .checksum(checksum),
`endif
    .count   (count)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 ns past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    n_cmp++;
    if ({s_ready, mem_we, busy, done, overflow} !== 5'b00000) begin
      n_bad++;
      $display("FAIL reset_flags got %b want 00000", {s_ready, mem_we, busy, done, overflow});
    end
    n_cmp++;
    if (count !== 6'd0 || mem_addr !== 5'd0 || mem_wd !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_regs got count=%0d addr=%0d wd=%h want 0 0 0", count, mem_addr, mem_wd);
    end
  endtask

  task automatic test_basic();
    logic [WIDTH-1:0] w [3];
    w[0] = 32'hE3A00001;
    w[1] = 32'hE2800002;
    w[2] = 32'hEAFFFFFE;
    pulse_start();
    n_cmp++;
    if (s_ready !== 1'b1 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL basic_load_state got ready=%b busy=%b want 1 1", s_ready, busy);
    end
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1;
      s_data  = w[i];
      s_last  = (i == 2);
      tick();
      n_cmp++;
      if (mem_we !== 1'b1 || mem_addr !== AW'(i) || mem_wd !== w[i]) begin
        n_bad++;
        $display("FAIL basic_write%0d got we=%b addr=%0d wd=%h want 1 %0d %h",
                 i, mem_we, mem_addr, mem_wd, i, w[i]);
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b0 || s_ready !== 1'b0 || count !== 6'd3 || overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_done got done=%b busy=%b ready=%b count=%0d ovf=%b want 1 0 0 3 0",
               done, busy, s_ready, count, overflow);
    end
    tick();
    n_cmp++;
    if (mem_we !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_we_idle got %b want 0", mem_we);
    end
  endtask

  // Valid toggles 1,0,1,0,...; a start pulse in a LOAD gap must be ignored.
  task automatic test_gaps();
    logic [WIDTH-1:0] w [3];
    w[0] = 32'h11111111;
    w[1] = 32'h22222222;
    w[2] = 32'h33333333;
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1;
      s_data  = w[i];
      s_last  = (i == 2);
      tick();
      n_cmp++;
      if (mem_we !== 1'b1 || mem_addr !== AW'(i) || mem_wd !== w[i]) begin
        n_bad++;
        $display("FAIL gaps_write%0d got we=%b addr=%0d wd=%h want 1 %0d %h",
                 i, mem_we, mem_addr, mem_wd, i, w[i]);
      end
      s_valid = 1'b0;
      s_last  = 1'b1;
      s_data  = 32'hDEADBEEF;
      start   = (i == 0);
      tick();
      start = 1'b0;
      n_cmp++;
      if (mem_we !== 1'b0) begin
        n_bad++;
        $display("FAIL gaps_idle%0d got we=%b want 0", i, mem_we);
      end
    end
    s_last = 1'b0;
    n_cmp++;
    if (done !== 1'b1 || count !== 6'd3 || overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL gaps_done got done=%b count=%0d ovf=%b want 1 3 0", done, count, overflow);
    end
  endtask

  task automatic test_exact_fit();
    int unsigned bad_writes = 0;
    pulse_start();
    for (int i = 0; i < SIZE; i++) begin
      s_valid = 1'b1;
      s_data  = 32'h1000 + 32'(i);
      s_last  = (i == SIZE - 1);
      tick();
      if (mem_we !== 1'b1 || mem_addr !== AW'(i) || mem_wd !== 32'h1000 + 32'(i)) begin
        bad_writes++;
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    n_cmp++;
    if (bad_writes != 0) begin
      n_bad++;
      $display("FAIL fit_writes got %0d bad writes want 0", bad_writes);
    end
    n_cmp++;
    if (mem_addr !== 5'd22 || count !== 6'd23 || overflow !== 1'b0 || done !== 1'b1) begin
      n_bad++;
      $display("FAIL fit_end got addr=%0d count=%0d ovf=%b done=%b want 22 23 0 1",
               mem_addr, count, overflow, done);
    end
  endtask

  task automatic test_overflow();
    int unsigned bad_writes = 0;
    pulse_start();
    for (int k = 0; k < 25; k++) begin
      s_valid = 1'b1;
      s_data  = 32'hA000 + 32'(k);
      s_last  = 1'b0;
      tick();
      if (k < SIZE) begin
        if (mem_we !== 1'b1 || mem_addr !== AW'(k) || mem_wd !== 32'hA000 + 32'(k)) bad_writes++;
      end else begin
        if (mem_we !== 1'b0) bad_writes++;
      end
      if (k == SIZE - 1) begin
        n_cmp++;
        if (s_ready !== 1'b0) begin
          n_bad++;
          $display("FAIL ovf_ready_after_last got %b want 0", s_ready);
        end
      end
    end
    s_valid = 1'b0;
    n_cmp++;
    if (bad_writes != 0) begin
      n_bad++;
      $display("FAIL ovf_writes got %0d bad cycles want 0", bad_writes);
    end
    n_cmp++;
    if (overflow !== 1'b1 || count !== 6'd23 || done !== 1'b1 || mem_addr !== 5'd22) begin
      n_bad++;
      $display("FAIL ovf_end got ovf=%b count=%0d done=%b addr=%0d want 1 23 1 22",
               overflow, count, done, mem_addr);
    end
  endtask

  // Start from DONE with a word already valid: that word is not accepted.
  task automatic test_restart();
    s_valid = 1'b1;
    s_data  = 32'h55AA55AA;
    s_last  = 1'b1;
    pulse_start();
    n_cmp++;
    if (mem_we !== 1'b0 || overflow !== 1'b0 || count !== 6'd0 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL restart got we=%b ovf=%b count=%0d busy=%b want 0 0 0 1",
               mem_we, overflow, count, busy);
    end
    tick();
    s_valid = 1'b0;
    s_last  = 1'b0;
    n_cmp++;
    if (mem_we !== 1'b1 || mem_addr !== 5'd0 || mem_wd !== 32'h55AA55AA || count !== 6'd1) begin
      n_bad++;
      $display("FAIL restart_write got we=%b addr=%0d wd=%h count=%0d want 1 0 55aa55aa 1",
               mem_we, mem_addr, mem_wd, count);
    end
  endtask

  task automatic test_reset_mid_load();
    pulse_start();
    s_valid = 1'b1;
    s_data  = 32'h0000AAAA;
    tick();
    s_data = 32'h0000BBBB;
    reset  = 1'b1;
    tick();
    reset   = 1'b0;
    s_valid = 1'b0;
    n_cmp++;
    if (mem_we !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || s_ready !== 1'b0 || count !== 6'd0) begin
      n_bad++;
      $display("FAIL midreset got we=%b busy=%b done=%b ready=%b count=%0d want 0 0 0 0 0",
               mem_we, busy, done, s_ready, count);
    end
    pulse_start();
    s_valid = 1'b1;
    s_data  = 32'h0000CCCC;
    s_last  = 1'b1;
    tick();
    s_valid = 1'b0;
    s_last  = 1'b0;
    n_cmp++;
    if (mem_we !== 1'b1 || mem_addr !== 5'd0 || mem_wd !== 32'h0000CCCC || count !== 6'd1 || done !== 1'b1) begin
      n_bad++;
      $display("FAIL midreset_reload got we=%b addr=%0d wd=%h count=%0d done=%b want 1 0 0000cccc 1 1",
               mem_we, mem_addr, mem_wd, count, done);
    end
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    pulse_start();
    s_valid = 1'b1;
    s_data  = 32'hFFFFFFFF;
    s_last  = 1'b0;
    tick();
    s_data = 32'h00000002;
    s_last = 1'b1;
    tick();
    s_valid = 1'b0;
    s_last  = 1'b0;
    n_cmp++;
    if (done !== 1'b1 || checksum !== 32'h00000001) begin
      n_bad++;
      $display("FAIL checksum got done=%b sum=%h want 1 00000001", done, checksum);
    end
  endtask
`endif

  initial begin
    reset   = 1'b0;
    start   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    s_last  = 1'b0;
    #1;
    test_reset();
    test_basic();
    test_gaps();
    test_exact_fit();
    test_overflow();
    test_restart();
    test_reset_mid_load();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_imem_loader
